// File: rtl/iso14443_rx_deframer_pkg.sv
// Shared types and helpers for the ISO14443 receive deframer.
// Holds the character FSM states and the COPRDSTAT bit positions.
package iso14443_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_GAP
  } rx_state_e;

  localparam int STAT_DONE  = 0;
  localparam int STAT_PERR  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_BUSY  = 3;
  localparam int STAT_EMPTY = 4;

  function automatic logic parity_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/iso14443_rx_deframer_fifo.sv
// Synchronous show-ahead byte FIFO for the receive path.
// Head byte reads as zero while the FIFO is empty.
module rx_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/iso14443_rx_deframer.sv
// ISO14443 card-side RX deframer: sync, bit timing, character FSM,
// byte FIFO and COPRD/COPRDLN/COPRDSTAT register views.
module iso14443_rx_deframer
  import iso14443_rx_pkg::*;
#(
  parameter int CLKS_PER_ETU = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int EOF_ETU      = 2
) (
  input  logic       clk_sc,
  input  logic       resetn,
  input  logic       serial_in,
  input  logic       rx_en,
  input  logic       rd_pop,
  output logic [7:0] rd_data,
  output logic [7:0] rd_len,
  output logic [7:0] rd_stat
);

  localparam int EOF_CLKS = EOF_ETU * CLKS_PER_ETU;
  localparam int TMAX     = (EOF_CLKS > CLKS_PER_ETU) ? EOF_CLKS
                                                      : CLKS_PER_ETU;
  localparam int TW       = $clog2(TMAX + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_ETU / 2 - 1);
  localparam logic [TW-1:0] ETU_M1  = TW'(CLKS_PER_ETU - 1);
  localparam logic [TW-1:0] EOF_M1  = TW'(EOF_CLKS - 1);

  rx_state_e     state;
  logic          sync1;
  logic          sync2;
  logic          line_q;
  logic          en_q;
  logic [TW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          from_gap;
  logic          push_pend;
  logic          frame_done;
  logic          perr;
  logic          ovf;

  logic          fall;
  logic          en_rise;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          unused_count;

  assign fall         = line_q & ~sync2;
  assign en_rise      = rx_en & ~en_q;
  assign unused_count = ^fifo_count;

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_sc),
    .resetn (resetn),
    .clr    (en_rise),
    .push   (push_pend),
    .pop    (rd_pop),
    .din    (shreg),
    .dout   (rd_data),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk_sc) begin
    if (!resetn) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      line_q     <= 1'b1;
      en_q       <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      from_gap   <= 1'b0;
      push_pend  <= 1'b0;
      frame_done <= 1'b0;
      perr       <= 1'b0;
      ovf        <= 1'b0;
      rd_len     <= '0;
    end else begin
      sync1     <= serial_in;
      sync2     <= sync1;
      line_q    <= sync2;
      en_q      <= rx_en;
      push_pend <= 1'b0;
      cnt       <= cnt + 1'b1;
      if (push_pend && fifo_full && !rd_pop) ovf <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (fall && rx_en) begin
            state    <= ST_START;
            cnt      <= '0;
            from_gap <= 1'b0;
            if (frame_done) begin
              frame_done <= 1'b0;
              rd_len     <= '0;
            end
          end
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!sync2) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state <= from_gap ? ST_GAP : ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (cnt == ETU_M1) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (cnt == ETU_M1) begin
            cnt       <= '0;
            push_pend <= 1'b1;
            state     <= ST_GAP;
            if (!parity_ok(shreg, sync2)) perr <= 1'b1;
            if (rd_len != 8'hFF) rd_len <= rd_len + 8'd1;
          end
        end
        ST_GAP: begin
          // cnt doubles as the run length of consecutive idle-high cycles
          if (fall) begin
            state    <= ST_START;
            cnt      <= '0;
            from_gap <= 1'b1;
          end else if (!sync2) begin
            cnt <= '0;
          end else if (cnt == EOF_M1) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (!rx_en) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end
      if (en_rise) begin
        rd_len     <= '0;
        frame_done <= 1'b0;
        perr       <= 1'b0;
        ovf        <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_stat             = '0;
    rd_stat[STAT_DONE]  = frame_done;
    rd_stat[STAT_PERR]  = perr;
    rd_stat[STAT_OVF]   = ovf;
    rd_stat[STAT_BUSY]  = (state != ST_IDLE);
    rd_stat[STAT_EMPTY] = fifo_empty;
  end

endmodule

// File: tb/tb_iso14443_rx_deframer.sv
// Directed and randomized bench for the ISO14443 RX deframer.
// Expectations come from a queue-based character/frame model.
module tb_iso14443_rx_deframer;

  localparam int ETU   = 16;
  localparam int DEPTH = 16;

  logic       clk_sc = 1'b0;
  logic       resetn;
  logic       serial_in;
  logic       rx_en;
  logic       rd_pop;
  logic [7:0] rd_data;
  logic [7:0] rd_len;
  logic [7:0] rd_stat;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] m_q[$];
  int         m_len;
  bit         m_done;
  bit         m_perr;
  bit         m_ovf;
  bit         m_busy;

  iso14443_rx_deframer #(
    .CLKS_PER_ETU (ETU),
    .FIFO_DEPTH   (DEPTH),
    .EOF_ETU      (2)
  ) dut (
    .clk_sc    (clk_sc),
    .resetn    (resetn),
    .serial_in (serial_in),
    .rx_en     (rx_en),
    .rd_pop    (rd_pop),
    .rd_data   (rd_data),
    .rd_len    (rd_len),
    .rd_stat   (rd_stat)
  );

  always #5 clk_sc = ~clk_sc;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_stat();
    return {3'b000, m_q.size() == 0, m_busy, m_ovf, m_perr, m_done};
  endfunction

  function automatic logic odd_p(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic m_clear();
    m_q.delete();
    m_len  = 0;
    m_done = 0;
    m_perr = 0;
    m_ovf  = 0;
    m_busy = 0;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    tick(ETU);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    tick(n);
  endtask

  task automatic send_char(input logic [7:0] d, input logic p);
    if (m_done) begin
      m_done = 0;
      m_len  = 0;
    end
    m_busy = 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    if ((^{d, p}) != 1'b1) m_perr = 1;
    if (m_q.size() < DEPTH) m_q.push_back(d);
    else m_ovf = 1;
    if (m_len != 255) m_len++;
  endtask

  task automatic end_frame(input int n);
    idle(n);
    m_busy = 0;
    m_done = 1;
  endtask

  task automatic pop_chk(input string tag);
    chk(tag, rd_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
    rd_pop = 1'b1;
    tick(1);
    rd_pop = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic restart();
    rx_en = 1'b0;
    tick(1);
    rx_en = 1'b1;
    tick(1);
    m_clear();
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    int         n;

    resetn    = 1'b0;
    serial_in = 1'b1;
    rx_en     = 1'b0;
    rd_pop    = 1'b0;
    m_clear();
    tick(3);
    chk("reset_stat", rd_stat, 8'h10);
    chk("reset_len", rd_len, 8'h00);
    chk("reset_data", rd_data, 8'h00);
    resetn = 1'b1;
    rx_en  = 1'b1;
    tick(2);

    // single byte frame
    send_char(8'h26, 1'b0);
    end_frame(40);
    chk("t1_data", rd_data, 8'h26);
    chk("t1_len", rd_len, 8'(m_len));
    chk("t1_stat", rd_stat, m_stat());
    chk("t1_stat_lit", rd_stat, 8'h01);
    pop_chk("t1_pop");
    chk("t1_stat_pop", rd_stat, 8'h11);

    // two byte frame with 1-ETU gap
    restart();
    send_char(8'h93, odd_p(8'h93));
    idle(ETU);
    chk("t2_mid_stat", rd_stat, m_stat());
    send_char(8'h20, odd_p(8'h20));
    end_frame(40);
    chk("t2_len", rd_len, 8'd2);
    chk("t2_stat", rd_stat, m_stat());
    pop_chk("t2_pop0");
    pop_chk("t2_pop1");
    chk("t2_stat_end", rd_stat, m_stat());

    // wrong parity
    restart();
    send_char(8'hA5, 1'b0);
    end_frame(40);
    chk("t3_data", rd_data, 8'hA5);
    chk("t3_perr", {7'b0, rd_stat[1]}, 8'h01);
    chk("t3_len", rd_len, 8'd1);
    chk("t3_stat", rd_stat, m_stat());

    // false start glitch
    restart();
    serial_in = 1'b0;
    tick(4);
    idle(40);
    chk("t4_stat", rd_stat, 8'h10);
    chk("t4_len", rd_len, 8'h00);

    // overflow with 17 bytes
    restart();
    for (int i = 0; i < 17; i++) begin
      d = 8'(i);
      send_char(d, odd_p(d));
      if (i != 16) idle(ETU);
    end
    end_frame(40);
    chk("t5_len", rd_len, 8'd17);
    chk("t5_stat", rd_stat, m_stat());
    chk("t5_ovf", {7'b0, rd_stat[2]}, 8'h01);
    for (int i = 0; i < 17; i++) pop_chk($sformatf("t5_pop%0d", i));
    chk("t5_stat_end", rd_stat, m_stat());

    // rx_en drop mid-character
    restart();
    send_char(8'h5C, odd_p(8'h5C));
    idle(ETU);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_en = 1'b0;
    tick(1);
    m_busy = 0;
    chk("t6_busy", {7'b0, rd_stat[3]}, 8'h00);
    chk("t6_stat_low", rd_stat, m_stat());
    chk("t6_data_low", rd_data, 8'h5C);
    serial_in = 1'b1;
    tick(4);
    rx_en = 1'b1;
    tick(1);
    m_clear();
    chk("t6_stat_rise", rd_stat, 8'h10);
    chk("t6_len_rise", rd_len, 8'h00);
    chk("t6_data_rise", rd_data, 8'h00);

    // reset mid-frame
    send_char(8'h3E, odd_p(8'h3E));
    idle(ETU);
    send_bit(1'b0);
    send_bit(1'b1);
    resetn = 1'b0;
    tick(1);
    m_clear();
    chk("t7_stat", rd_stat, 8'h10);
    chk("t7_len", rd_len, 8'h00);
    chk("t7_data", rd_data, 8'h00);
    serial_in = 1'b1;
    resetn    = 1'b1;
    tick(4);

    // randomized frames, sticky errors carried across frames
    restart();
    for (int f = 0; f < 5; f++) begin
      n = $urandom_range(1, 5);
      for (int c = 0; c < n; c++) begin
        d = 8'($urandom);
        p = odd_p(d) ^ ($urandom_range(0, 3) == 0);
        send_char(d, p);
        if (c != n - 1) idle($urandom_range(ETU, ETU + 8));
      end
      end_frame(48);
      chk($sformatf("r%0d_len", f), rd_len, 8'(m_len));
      chk($sformatf("r%0d_stat", f), rd_stat, m_stat());
      for (int c = 0; c < n; c++) pop_chk($sformatf("r%0d_pop%0d", f, c));
      chk($sformatf("r%0d_stat_end", f), rd_stat, m_stat());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
